// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and the next-PC source encoding for the fetch unit.
package arm_pc_pkg;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
   localparam int unsigned DEFAULT_PC_STEP      = 1;

   // Which source the next PC is taken from, highest priority last.
   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BRANCH,
      SRC_RET,
      SRC_STALL,
      SRC_TRAP
   } pc_src_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between the pipeline front end and the fetch unit.
interface pc_fetch_unit_if #(
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned RAS_DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

   logic                stall;
   logic                branch_taken;
   logic [PC_WIDTH-1:0] branch_target;
   logic                call;
   logic                ret;
   logic [PC_WIDTH-1:0] ret_fallback;
   logic                trap;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_next;
   logic [CNT_W-1:0]    ras_count;
   logic                ras_overflow;
   logic                ret_miss;
   logic [31:0]         cycle_count;
   logic [31:0]         stall_count;

   // Front end: drives control, observes the PC and status.
   modport master (
      output stall, branch_taken, branch_target, call, ret, ret_fallback, trap,
      input  pc, pc_next, ras_count, ras_overflow, ret_miss, cycle_count, stall_count
   );

   // Fetch unit side.
   modport slave (
      input  stall, branch_taken, branch_target, call, ret, ret_fallback, trap,
      output pc, pc_next, ras_count, ras_overflow, ret_miss, cycle_count, stall_count
   );

endinterface

// File: rtl/pc_fetch_unit_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// a simultaneous push+pop replaces the top in place.
module ras_stack #(
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [PC_WIDTH-1:0]          push_data,
   output logic [PC_WIDTH-1:0]          top,
   output logic [$clog2(RAS_DEPTH):0]   count,
   output logic                         overflow
);
   localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

   logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [IDX_W-1:0]    tos_q, tos_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                wr_en;
   logic [IDX_W-1:0]    wr_idx;

   // Pointer/count update; the index wraps naturally because depth is a power of two.
   always_comb begin
      tos_d   = tos_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = tos_q;
      if (push && pop && (count_q != '0)) begin
         wr_en = 1'b1;
      end else if (push) begin
         tos_d  = tos_q + IDX_W'(1);
         wr_idx = tos_q + IDX_W'(1);
         wr_en  = 1'b1;
         if (count_q == FULL) ovf_d = 1'b1;
         else                 count_d = count_q + CNT_W'(1);
      end else if (pop && (count_q != '0)) begin
         tos_d   = tos_q - IDX_W'(1);
         count_d = count_q - CNT_W'(1);
      end
   end

   // Control state: pointer, occupancy and the overflow pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tos_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Entry storage needs no reset: nothing reads it while the count is zero.
   always_ff @(posedge clock) begin
      if (wr_en && reset) mem_q[wr_idx] <= push_data;
   end

   assign top      = mem_q[tos_q];
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with trap/stall/return/branch priority, a return-address
// stack for calls, and free-running cycle and stall counters.
module pc_fetch_unit
   import arm_pc_pkg::*;
#(
   parameter int unsigned         PC_WIDTH     = 32,
   parameter int unsigned         PC_STEP      = DEFAULT_PC_STEP,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(DEFAULT_TRAP_VECTOR),
   parameter int unsigned         RAS_DEPTH    = 4
) (
   input  logic           clock,
   input  logic           reset,
   pc_fetch_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;
   localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] seq_pc;
   logic [PC_WIDTH-1:0] ras_top;
   logic [CNT_W-1:0]    ras_cnt;
   logic                ras_empty;
   logic                ras_ovf;
   logic                active;
   logic                push, pop;
   logic                ret_miss_q, ret_miss_d;
   logic [31:0]         cycle_q, cycle_d;
   logic [31:0]         stall_cnt_q, stall_cnt_d;
   pc_src_e             src;

   assign seq_pc    = pc_q + STEP;
   assign ras_empty = (ras_cnt == '0);

   // Trap and stall both freeze the stack; only an unblocked cycle may push/pop.
   assign active     = !bus.trap && !bus.stall;
   assign push       = active && bus.branch_taken && bus.call;
   assign pop        = active && bus.ret && !ras_empty;
   assign ret_miss_d = active && bus.ret && ras_empty;

   // Source selection in priority order.
   always_comb begin
      src = SRC_SEQ;
      if (bus.trap)              src = SRC_TRAP;
      else if (bus.stall)        src = SRC_STALL;
      else if (bus.ret)          src = SRC_RET;
      else if (bus.branch_taken) src = SRC_BRANCH;
   end

   // Next-PC mux; an empty stack falls back to the externally supplied address.
   always_comb begin
      pc_d = seq_pc;
      case (src)
         SRC_TRAP:   pc_d = TRAP_VECTOR;
         SRC_STALL:  pc_d = pc_q;
         SRC_RET:    pc_d = ras_empty ? bus.ret_fallback : ras_top;
         SRC_BRANCH: pc_d = bus.branch_target;
         default:    pc_d = seq_pc;
      endcase
   end

   assign cycle_d     = cycle_q + 32'd1;
   assign stall_cnt_d = (bus.stall && !bus.trap) ? stall_cnt_q + 32'd1 : stall_cnt_q;

   // PC, return-miss pulse and counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q        <= RESET_VECTOR;
         ret_miss_q  <= 1'b0;
         cycle_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         ret_miss_q  <= ret_miss_d;
         cycle_q     <= cycle_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   ras_stack #(
      .PC_WIDTH  (PC_WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .count     (ras_cnt),
      .overflow  (ras_ovf)
   );

   assign bus.pc           = pc_q;
   assign bus.pc_next      = pc_d;
   assign bus.ras_count    = ras_cnt;
   assign bus.ras_overflow = ras_ovf;
   assign bus.ret_miss     = ret_miss_q;
   assign bus.cycle_count  = cycle_q;
   assign bus.stall_count  = stall_cnt_q;

endmodule
